// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encoding and 8N1 frame constants.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

    typedef logic [DATA_BITS-1:0] data_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte write port of the UART transmitter: push request, data and the
// registered FIFO status flags.
interface uart_tx_fifo_if;
    import uart_tx_fifo_pkg::*;

    logic  wr_en;
    data_t wr_data;
    logic  full;
    logic  empty;

    modport master (output wr_en, output wr_data, input  full, input  empty);
    modport slave  (input  wr_en, input  wr_data, output full, output empty);

endinterface

// File: rtl/uart_tx_fifo_fifo.sv
// Synchronous FIFO of 2^ADDR_W words with registered full/empty flags;
// pushes while full are dropped silently.
module fifo_sync #(
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_next;
    logic              do_push;
    logic              do_pop;

    // A push is refused on the registered full flag, even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (ADDR_W+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which words are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes written through the port are queued
// in a FIFO and serialized at CLK_FREQ/BAUD clocks per bit.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int ADDR_W   = 3
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.slave  wr,
    output logic           tx,
    output logic           tx_busy,
    output logic           tx_done
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BIT_END = CNT_W'(DIV - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [CNT_W-1:0]      baud_cnt;
    logic [CNT_W-1:0]      baud_cnt_next;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic [BIT_IDX_W-1:0]  bit_idx_next;
    data_t                 shift;
    data_t                 shift_next;
    logic                  tx_next;
    logic                  bit_end;
    logic                  pop;
    data_t                 rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    fifo_sync #(
        .ADDR_W (ADDR_W),
        .WIDTH  (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr.wr_en),
        .pop     (pop),
        .wr_data (wr.wr_data),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign wr.full  = fifo_full;
    assign wr.empty = fifo_empty;
    assign bit_end  = (baud_cnt == BIT_END);
    assign tx_busy  = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= IDLE_LEVEL;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            tx       <= tx_next;
        end
    end

    // tx is registered from tx_next, so each line level appears one edge after its decision.
    always_comb begin
        state_next    = state;
        baud_cnt_next = baud_cnt + 1'b1;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        tx_next       = tx;
        pop           = 1'b0;
        tx_done       = 1'b0;

        unique case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (!fifo_empty) begin
                    state_next = START;
                    pop        = 1'b1;
                    shift_next = rd_data;
                    tx_next    = START_LEVEL;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next    = DATA;
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    tx_next       = shift[0];
                    shift_next    = shift >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_next = '0;
                    if (bit_idx == LAST_BIT) begin
                        state_next = STOP;
                        tx_next    = STOP_LEVEL;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        tx_next      = shift[0];
                        shift_next   = shift >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next    = IDLE;
                    baud_cnt_next = '0;
                    tx_done       = 1'b1;
                end
            end
            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
                tx_next       = IDLE_LEVEL;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo at DIV=10: stimulus queues expected bytes,
// a serial monitor decodes every frame and checks bit timing and flags.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    logic clk;
    logic reset;
    logic tx;
    logic tx_busy;
    logic tx_done;

    uart_tx_fifo_if wr_if ();

    uart_tx_fifo #(
        .CLK_FREQ (100),
        .BAUD     (10),
        .ADDR_W   (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr_if.slave),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb_q [$];
    int         gap_q [$];
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    int         idle_run   = 0;
    int         done_cnt   = 0;
    logic [9:0] frame      = '1;
    logic       prev_tx    = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Serial monitor: a frame is 100 clocks (start, 8 data LSB first, stop)
    // and tx_done must be high only on its last clock.
    always @(negedge clk) begin
        if (reset) begin
            mon_active = 1'b0;
            idle_run   = 0;
        end else begin
            if (tx_done) done_cnt++;
            if (!mon_active && prev_tx && !tx) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                gap_q.push_back(idle_run);
                check("frame_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) frame = {1'b1, sb_q.pop_front(), 1'b0};
                else                  frame = {1'b1, 8'h00, 1'b0};
            end
            if (mon_active) begin
                mon_cnt++;
                check("tx_bit", tx, frame[(mon_cnt - 1) / 10]);
                check("tx_busy_in_frame", tx_busy, 1);
                check("tx_done_timing", tx_done, (mon_cnt == 100));
                if (mon_cnt == 100) begin
                    mon_active = 1'b0;
                    idle_run   = 0;
                end
            end else begin
                check("idle_tx", tx, 1);
                check("idle_tx_busy", tx_busy, 0);
                check("idle_tx_done", tx_done, 0);
                idle_run++;
            end
        end
        prev_tx = tx;
    end

    task automatic push(input logic [7:0] d, input bit accepted);
        @(negedge clk);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_data = d;
        if (accepted) sb_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic release_bus;
        @(negedge clk);
        wr_if.wr_en = 1'b0;
    endtask

    task automatic drain(input int limit);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(negedge clk);
            if (!mon_active && sb_q.size() == 0 && !tx_busy && wr_if.empty) ok = 1'b1;
        end
        check("drain_complete", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d0;
        bit  seen;
        reset         = 1'b1;
        wr_if.wr_en   = 1'b0;
        wr_if.wr_data = '0;

        // Reset state
        #3;
        check("rst_tx", tx, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_empty", wr_if.empty, 1);
        check("rst_full", wr_if.full, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle stability: the monitor flags any activity
        d0 = done_cnt;
        repeat (1000) @(negedge clk);
        check("idle_no_done", done_cnt - d0, 0);
        check("idle_empty", wr_if.empty, 1);

        // Single byte 0xA5
        d0 = done_cnt;
        push(8'hA5, 1);
        check("a5_empty_after_push", wr_if.empty, 0);
        check("a5_tx_still_high", tx, 1);
        check("a5_busy_before_start", tx_busy, 0);
        release_bus();
        @(posedge clk); #1;
        check("a5_tx_low_after_pop", tx, 0);
        check("a5_empty_after_pop", wr_if.empty, 1);
        check("a5_busy_after_pop", tx_busy, 1);
        for (int i = 0; i < 95; i++) begin
            @(negedge clk);
            check("a5_empty_during_frame", wr_if.empty, 1);
        end
        drain(300);
        check("a5_done_pulses", done_cnt - d0, 1);

        // Back-to-back frames
        d0 = done_cnt;
        gap_q.delete();
        push(8'h00, 1);
        push(8'hFF, 1);
        push(8'h55, 1);
        release_bus();
        drain(600);
        check("b2b_done_pulses", done_cnt - d0, 3);
        check("b2b_frames", gap_q.size(), 3);
        if (gap_q.size() == 3) begin
            check("b2b_gap1", gap_q[1], 1);
            check("b2b_gap2", gap_q[2], 1);
        end

        // Overflow from idle: nine pushes, the first pops immediately
        for (int i = 1; i <= 9; i++) begin
            push(8'(i), 1);
            if (i == 8) check("ovf_full_after_8", wr_if.full, 0);
        end
        check("ovf_full_after_9", wr_if.full, 1);
        release_bus();
        drain(2000);
        check("ovf_full_cleared", wr_if.full, 0);

        // Overflow during a frame: 0x0A and the held 0xEE must be dropped
        push(8'h01, 1);
        release_bus();
        repeat (5) @(negedge clk);
        for (int i = 2; i <= 9; i++) push(8'(i), 1);
        check("ovf2_full", wr_if.full, 1);
        push(8'h0A, 0);
        check("ovf2_full_after_drop", wr_if.full, 1);
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (wr_if.full) begin
                wr_if.wr_en   = 1'b1;
                wr_if.wr_data = 8'hEE;
            end else begin
                wr_if.wr_en = 1'b0;
                seen        = 1'b1;
            end
        end
        check("ovf2_full_released", seen, 1);
        drain(2000);

        // Simultaneous push and pop with three bytes queued
        push(8'h10, 1);
        release_bus();
        repeat (5) @(negedge clk);
        push(8'h20, 1);
        push(8'h30, 1);
        push(8'h40, 1);
        release_bus();
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (tx_done) seen = 1'b1;
        end
        check("sim_done_seen", seen, 1);
        push(8'h50, 1);
        check("sim_empty_at_pop", wr_if.empty, 0);
        check("sim_full_at_pop", wr_if.full, 0);
        push(8'h60, 1);
        push(8'h70, 1);
        push(8'h80, 1);
        push(8'h90, 1);
        check("sim_full_at_7", wr_if.full, 0);
        push(8'hA0, 1);
        check("sim_full_at_8", wr_if.full, 1);
        release_bus();
        drain(1500);

        // Reset during bit 3 of 0x3C with two bytes queued
        push(8'h3C, 1);
        push(8'h77, 1);
        push(8'h88, 1);
        release_bus();
        repeat (43) @(negedge clk);
        check("mid_busy_before_reset", tx_busy, 1);
        check("mid_empty_before_reset", wr_if.empty, 0);
        #2;
        reset = 1'b1;
        sb_q.delete();
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_empty", wr_if.empty, 1);
        check("mid_rst_full", wr_if.full, 0);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_done", tx_done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (300) @(negedge clk);
        check("mid_no_restart", done_cnt - d0, 0);
        check("mid_empty_after", wr_if.empty, 1);
        push(8'hC3, 1);
        release_bus();
        drain(300);
        check("mid_new_frame_done", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the serial bit rate in bit/s.
REQ-003 SHALL have parameter ADDR_W, default 3, meaning log2 of the FIFO depth (default depth 8).
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port wr_en, input, 1 bit: push request, sampled on the rising clk edge.
REQ-007 SHALL have port wr_data, input, 8 bits: byte to push.
REQ-008 SHALL have port full, output, 1 bit: FIFO holds 2^ADDR_W bytes.
REQ-009 SHALL have port empty, output, 1 bit: FIFO holds 0 bytes.
REQ-010 SHALL have port tx, output, 1 bit: registered serial line, idle high.
REQ-011 SHALL have port tx_busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-012 SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of each stop bit.

Function
REQ-013 SHALL use DIV = CLK_FREQ/BAUD, integer-truncated (10416 at default), as clocks per bit.
REQ-014 SHALL clear the baud counter on every state or bit transition, so each bit lasts exactly DIV clocks.
REQ-015 SHALL frame every byte as 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
REQ-016 SHALL implement the FSM states IDLE, START, DATA, STOP.
REQ-017 SHALL transition IDLE -> START when empty=0; the same edge pops one byte into the shift register.
REQ-018 SHALL transition START -> DATA after DIV clocks.
REQ-019 SHALL transition DATA -> STOP after 8×DIV clocks, using a 3-bit index from 0 to 7.
REQ-020 SHALL transition STOP -> IDLE after DIV clocks.
REQ-021 SHALL assert tx_done for exactly the cycle in which STOP exits.
REQ-022 SHALL start the next frame one clock after STOP exit when empty=0, leaving 1 extra idle-high clock between frames.
REQ-023 SHALL, on a write to an empty idle block at edge N, deassert empty after edge N and drive tx low after edge N+1.
REQ-024 SHALL ignore wr_en while full=1, including in a cycle where a pop occurs; the contents are left unchanged and no error flag is raised.
REQ-025 SHALL, on a simultaneous push and pop when 0 < count < depth, perform both operations and leave the count unchanged.
REQ-026 SHALL wrap the FIFO pointers modulo 2^ADDR_W.
REQ-027 SHALL use an (ADDR_W+1)-bit count, or an extra pointer bit, to distinguish full from empty.
REQ-028 SHALL register full and empty so that they reflect the state after each edge.

Reset
REQ-029 SHALL, on reset assertion (asynchronous, including mid-frame), immediately force tx=1, tx_busy=0, tx_done=0, empty=1, full=0, state=IDLE.
REQ-030 SHALL, on reset assertion, also clear the pointers, count, baud counter and bit index.
REQ-031 SHALL discard any partially sent byte and all buffered bytes on reset.
REQ-032 SHALL, on reset release, resume normal operation at the first clk edge; the FIFO memory contents need not be reset.

Structure
REQ-033 SHALL place the FSM state encoding and the 8N1 frame-length constants in the shared project package.
REQ-034 SHALL compute DIV and the counter width locally from the parameters.
REQ-035 SHALL implement the buffer as one sub-module, fifo_sync (parameters ADDR_W and width 8), providing push, pop, full and empty.
REQ-036 SHALL keep the serializer FSM and the baud counter in uart_tx_fifo itself, and use no other sub-modules.

Verification (bench overrides CLK_FREQ=100, BAUD=10, so DIV=10)
REQ-037 SHALL cover a single byte: push 0xA5 once -> tx low 10 clk, then bits 1,0,1,0,0,1,0,1 at 10 clk each, then high 10 clk; tx_done pulses once; empty=1 throughout the frame after the pop.
REQ-038 SHALL cover back-to-back frames: push 0x00,0xFF,0x55 on consecutive clocks -> three frames each 100 clk long, separated by 1 idle clock; three tx_done pulses; tx_busy low only in the gaps.
REQ-039 SHALL cover overflow: while idle under reset-hold release, push 9 bytes 0x01..0x09 on consecutive clocks -> the first byte pops, full asserts after byte 9, and the serial output is 0x01..0x09 with none lost; repeated with depth filled during a frame -> the 10th push is ignored and 0x0A is never transmitted.
REQ-040 SHALL cover reset mid-frame: assert reset at bit 3 of 0x3C with 2 bytes queued -> tx=1 and empty=1 in the same cycle; after release no frame starts until a new push.
REQ-041 SHALL cover simultaneous push/pop: with 3 bytes queued, push on the exact pop edge -> count stays 3 and byte order is preserved on tx.
REQ-042 SHALL cover idle stability: no pushes for 1000 clk after reset -> tx constantly 1, tx_busy=0, and tx_done never pulses.
